alu_control_mdu: RTL and testbench

// EX-stage ALU control decoder plus parametrised iterative multiply/divide unit (MDU) with HI/LO.

---
 rtl/alu_control_mdu.sv | 175 +++++++++++++++++
 tb/tb_alu_control_mdu.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_mdu.sv
// EX-stage ALU control decoder with an iterative multiply/divide unit holding HI/LO.
// The MDU retires STEP bits per RUN cycle and signs the result in a final FIXUP cycle.
module alu_control_mdu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Valid,
  input  logic             Flush,
  input  logic [1:0]       ALUop,
  input  logic [5:0]       Function,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic [3:0]       ALUControl,
  output logic             Jr,
  output logic             IllegalFunct,
  output logic             MdSel,
  output logic [WIDTH-1:0] MdResult,
  output logic             Busy,
  output logic             Stall
);

  localparam int unsigned N  = WIDTH / STEP;
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFixup} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, sh_q, mb_q, hi_q, lo_q;
  logic             div_q, a_neg_q, b_neg_q, b_zero_q;

  logic r_fmt, is_mf, is_arith, md_op, start;
  logic sgn, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    ALUControl   = 4'b1111;
    Jr           = 1'b0;
    IllegalFunct = 1'b0;
    MdSel        = 1'b0;
    unique case (ALUop)
      2'b00: ALUControl = 4'b0010;
      2'b01: ALUControl = 4'b0110;
      2'b11: ALUControl = 4'b0000;
      2'b10: begin
        case (Function)
          6'h20, 6'h21: ALUControl = 4'b0010;
          6'h22, 6'h23: ALUControl = 4'b0110;
          6'h24:        ALUControl = 4'b0000;
          6'h25:        ALUControl = 4'b0001;
          6'h26:        ALUControl = 4'b0011;
          6'h27:        ALUControl = 4'b1100;
          6'h2A:        ALUControl = 4'b0111;
          6'h2B:        ALUControl = 4'b1000;
          6'h00:        ALUControl = 4'b1110;
          6'h02:        ALUControl = 4'b1101;
          6'h08:        Jr = 1'b1;
          6'h10, 6'h12: MdSel = 1'b1;
          6'h18, 6'h19, 6'h1A, 6'h1B: ;
          default:      IllegalFunct = 1'b1;
        endcase
      end
      default: ALUControl = 4'b1111;
    endcase
  end

  assign r_fmt    = (ALUop == 2'b10);
  assign is_mf    = (Function == 6'h10) || (Function == 6'h12);
  assign is_arith = (Function[5:2] == 4'b0110);
  assign md_op    = Valid & r_fmt & (is_mf | is_arith);
  assign Busy     = (state_q != StIdle);
  assign Stall    = md_op & Busy;
  assign start    = Valid & r_fmt & is_arith & ~Busy & ~Flush;
  assign MdResult = (Function == 6'h10) ? hi_q : lo_q;

  // Funct bit 0 clear selects the signed variants (MULT, DIV).
  assign sgn   = ~Function[0];
  assign a_neg = sgn & OpA[WIDTH-1];
  assign b_neg = sgn & OpB[WIDTH-1];
  assign mag_a = a_neg ? -OpA : OpA;
  assign mag_b = b_neg ? -OpB : OpB;

  // acc holds the running upper product / partial remainder; sh the multiplier / quotient.
  logic [WIDTH-1:0] acc_n, sh_n;
  logic [WIDTH:0]   sum;

  always_comb begin
    acc_n = acc_q;
    sh_n  = sh_q;
    sum   = '0;
    for (int i = 0; i < STEP; i++) begin
      if (div_q) begin
        sum  = {acc_n, sh_n[WIDTH-1]};
        sh_n = {sh_n[WIDTH-2:0], 1'b0};
        if (sum >= {1'b0, mb_q}) begin
          sum     = sum - {1'b0, mb_q};
          sh_n[0] = 1'b1;
        end
        acc_n = sum[WIDTH-1:0];
      end else begin
        sum   = {1'b0, acc_n} + (sh_n[0] ? {1'b0, mb_q} : '0);
        sh_n  = {sum[0], sh_n[WIDTH-1:1]};
        acc_n = sum[WIDTH:1];
      end
    end
  end

  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   q_s, r_s, hi_fix, lo_fix;

  always_comb begin
    prod   = {acc_q, sh_q};
    prod_s = (a_neg_q ^ b_neg_q) ? -prod : prod;
    q_s    = (a_neg_q ^ b_neg_q) ? -sh_q : sh_q;
    r_s    = a_neg_q ? -acc_q : acc_q;
    if (div_q) begin
      // Divide by zero leaves |OpA| in the remainder, so HI comes back as OpA.
      lo_fix = b_zero_q ? '1 : q_s;
      hi_fix = r_s;
    end else begin
      hi_fix = prod_s[2*WIDTH-1:WIDTH];
      lo_fix = prod_s[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      mb_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      div_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
    end else if (Flush && state_q != StIdle) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StRun;
            cnt_q    <= CW'(N);
            acc_q    <= '0;
            sh_q     <= mag_a;
            mb_q     <= mag_b;
            div_q    <= Function[1];
            a_neg_q  <= a_neg;
            b_neg_q  <= b_neg;
            b_zero_q <= (OpB == '0);
          end
        end
        StRun: begin
          acc_q <= acc_n;
          sh_q  <= sh_n;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_q <= StFixup;
        end
        StFixup: begin
          hi_q    <= hi_fix;
          lo_q    <= lo_fix;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_mdu.sv
// Bench for alu_control_mdu: a 32-bit/STEP=1 instance and a 16-bit/STEP=4 instance,
// driven with directed vectors; expected responses are queued and checked by monitors.
module tb_alu_control_mdu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0, flush = 1'b0;
  logic [1:0]  aluop = 2'b00;
  logic [5:0]  funct = 6'h00;
  logic [31:0] opa = '0, opb = '0;
  logic [3:0]  alu_ctl;
  logic        jr, ill, mdsel, busy, stall;
  logic [31:0] mdres;

  logic        v16 = 1'b0;
  logic [5:0]  fn16 = 6'h00;
  logic [15:0] a16 = '0, b16 = '0;
  logic [3:0]  ctl16;
  logic        jr16, ill16, ms16, busy16, stall16;
  logic [15:0] md16;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [6:0]  dec;   // {ALUControl, Jr, IllegalFunct, MdSel}
    logic        chk;
    logic [31:0] md;
  } exp_t;

  exp_t        q[$];
  logic [15:0] q16[$];

  always #5 clk = ~clk;

  alu_control_mdu #(.WIDTH(32), .STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .Valid(valid), .Flush(flush), .ALUop(aluop),
    .Function(funct), .OpA(opa), .OpB(opb), .ALUControl(alu_ctl), .Jr(jr),
    .IllegalFunct(ill), .MdSel(mdsel), .MdResult(mdres), .Busy(busy), .Stall(stall)
  );

  alu_control_mdu #(.WIDTH(16), .STEP(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .Valid(v16), .Flush(1'b0), .ALUop(2'b10),
    .Function(fn16), .OpA(a16), .OpB(b16), .ALUControl(ctl16), .Jr(jr16),
    .IllegalFunct(ill16), .MdSel(ms16), .MdResult(md16), .Busy(busy16), .Stall(stall16)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // An instruction retires on any non-stalled cycle with Valid high.
  always @(negedge clk) begin
    if (rst_n && valid && !stall) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL monitor_empty: retired funct %0h with nothing expected", funct);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk($sformatf("decode_op%0d_f%0h", aluop, funct), {alu_ctl, jr, ill, mdsel}, e.dec);
        if (e.chk) chk($sformatf("mdresult_f%0h", funct), mdres, e.md);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && v16 && ms16 && !stall16) begin
      if (q16.size() == 0) begin
        total++;
        bad++;
        $display("FAIL monitor16_empty: read funct %0h with nothing expected", fn16);
      end else begin
        chk($sformatf("md16_f%0h", fn16), {ctl16, jr16, ill16, md16}, {4'b1111, 2'b00, q16.pop_front()});
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [6:0] d, input logic chkmd,
                       input logic [31:0] md, output int stalls);
    exp_t e;
    bit   done;
    valid = 1'b1; aluop = op; funct = fn; opa = a; opb = b;
    e.dec = d; e.chk = chkmd; e.md = md;
    q.push_back(e);
    stalls = 0;
    done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (!stall) done = 1;
      else stalls++;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: funct %0h stalled %0d cycles, limit 200", fn, stalls);
    end
    valid = 1'b0;
  endtask

  task automatic dec(input logic [1:0] op, input logic [5:0] fn, input logic [6:0] d);
    int s;
    issue(op, fn, 32'h0, 32'h0, d, 1'b0, 32'h0, s);
  endtask

  task automatic mdu(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    int s;
    issue(2'b10, fn, a, b, 7'b1111_000, 1'b0, 32'h0, s);
  endtask

  task automatic rd(input logic [5:0] fn, input logic [31:0] md, output int s);
    issue(2'b10, fn, 32'h0, 32'h0, 7'b1111_001, 1'b1, md, s);
  endtask

  task automatic op16(input logic [5:0] fn, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] hi, input logic [15:0] lo);
    int n;
    v16 = 1'b1; fn16 = fn; a16 = a; b16 = b;
    @(posedge clk); #1;
    v16 = 1'b0;
    n = 0;
    while (busy16 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("latency16_f%0h", fn), n, 5);
    v16 = 1'b1; fn16 = 6'h12; q16.push_back(lo);
    @(posedge clk); #1;
    fn16 = 6'h10; q16.push_back(hi);
    @(posedge clk); #1;
    v16 = 1'b0;
  endtask

  initial begin
    int s;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_busy", busy, 0);
    chk("reset_stall", stall, 0);
    rd(6'h10, 32'h0, s);
    rd(6'h12, 32'h0, s);

    // Decode sweep: {ALUControl, Jr, IllegalFunct, MdSel}.
    dec(2'b00, 6'h08, 7'b0010_000);
    dec(2'b01, 6'h3F, 7'b0110_000);
    dec(2'b11, 6'h10, 7'b0000_000);
    dec(2'b10, 6'h20, 7'b0010_000);
    dec(2'b10, 6'h21, 7'b0010_000);
    dec(2'b10, 6'h22, 7'b0110_000);
    dec(2'b10, 6'h23, 7'b0110_000);
    dec(2'b10, 6'h24, 7'b0000_000);
    dec(2'b10, 6'h25, 7'b0001_000);
    dec(2'b10, 6'h26, 7'b0011_000);
    dec(2'b10, 6'h27, 7'b1100_000);
    dec(2'b10, 6'h2A, 7'b0111_000);
    dec(2'b10, 6'h2B, 7'b1000_000);
    dec(2'b10, 6'h00, 7'b1110_000);
    dec(2'b10, 6'h02, 7'b1101_000);
    dec(2'b10, 6'h08, 7'b1111_100);
    dec(2'b10, 6'h10, 7'b1111_001);
    dec(2'b10, 6'h12, 7'b1111_001);
    dec(2'b10, 6'h3F, 7'b1111_010);
    dec(2'b10, 6'h01, 7'b1111_010);
    dec(2'b10, 6'h18, 7'b1111_000);
    dec(2'b10, 6'h19, 7'b1111_000);
    dec(2'b10, 6'h1A, 7'b1111_000);
    dec(2'b10, 6'h1B, 7'b1111_000);

    mdu(6'h18, 32'hFFFF_FFFF, 32'h2);
    rd(6'h12, 32'hFFFF_FFFE, s);
    chk("mflo_stall_cycles", s, 33);
    rd(6'h10, 32'hFFFF_FFFF, s);

    mdu(6'h19, 32'hFFFF_FFFF, 32'h2);
    rd(6'h10, 32'h0000_0001, s);
    rd(6'h12, 32'hFFFF_FFFE, s);

    mdu(6'h18, 32'd6, 32'd7);
    issue(2'b10, 6'h20, 32'd1, 32'd2, 7'b0010_000, 1'b0, 32'h0, s);
    chk("add_while_busy_stall", s, 0);
    chk("busy_during_add", busy, 1);
    dec(2'b10, 6'h26, 7'b0011_000);
    rd(6'h12, 32'd42, s);
    rd(6'h10, 32'h0, s);

    mdu(6'h1A, 32'hFFFF_FFF9, 32'h2);
    rd(6'h12, 32'hFFFF_FFFD, s);
    rd(6'h10, 32'hFFFF_FFFF, s);

    // Flush during RUN cycle 10 abandons the multiply.
    mdu(6'h18, 32'd3, 32'd5);
    chk("busy_in_run", busy, 1);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("busy_after_flush", busy, 0);
    rd(6'h10, 32'hFFFF_FFFF, s);
    chk("mfhi_after_flush_stall", s, 0);
    rd(6'h12, 32'hFFFF_FFFD, s);

    flush = 1'b1;
    mdu(6'h18, 32'd3, 32'd5);
    flush = 1'b0;
    chk("flush_blocks_start", busy, 0);

    mdu(6'h1B, 32'd7, 32'd0);
    rd(6'h12, 32'hFFFF_FFFF, s);
    rd(6'h10, 32'h0000_0007, s);

    mdu(6'h1A, 32'hFFFF_FFF9, 32'd0);
    rd(6'h12, 32'hFFFF_FFFF, s);
    rd(6'h10, 32'hFFFF_FFF9, s);

    mdu(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
    rd(6'h12, 32'h8000_0000, s);
    rd(6'h10, 32'h0, s);

    // Asynchronous reset mid-RUN clears HI/LO and the FSM.
    mdu(6'h19, 32'd3, 32'd5);
    repeat (4) @(posedge clk);
    chk("busy_before_reset", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk("busy_in_reset", busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("busy_after_reset", busy, 0);
    rd(6'h10, 32'h0, s);
    rd(6'h12, 32'h0, s);

    op16(6'h18, 16'h8000, 16'h8000, 16'h4000, 16'h0000);
    op16(6'h19, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001);
    op16(6'h18, 16'h1234, 16'hFFFE, 16'hFFFF, 16'hDB98);
    op16(6'h1A, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000);
    op16(6'h1A, 16'h0064, 16'hFFF9, 16'h0002, 16'hFFF2);
    op16(6'h1A, 16'hFF9C, 16'h0007, 16'hFFFE, 16'hFFF2);
    op16(6'h1B, 16'hFFFF, 16'h0010, 16'h000F, 16'h0FFF);

    repeat (2) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    chk("queue16_drained", q16.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
